// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite register bank with parallel register outputs and per-register write pulses
// Optional feature: define AXIL_REG_WSTRB_EN to honour wstrb byte lanes on register writes.
module axil_reg_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q;

    logic [0:0]          wstate_q;
    logic                aw_held_q;
    logic                w_held_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [1:0]          bresp_q;

    logic [0:0]          rstate_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                wr_commit;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic [ADDR_W-1:0]   wr_off;
    logic                wr_hit;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wr_word;
    logic [ADDR_W-1:0]   rd_off;
    logic                rd_hit;
    logic [IDX_W-1:0]    rd_idx;
    logic                unused_bits;

    assign awready      = (wstate_q == W_IDLE) && !aw_held_q;
    assign wready       = (wstate_q == W_IDLE) && !w_held_q;
    assign bvalid       = (wstate_q == W_RESP);
    assign bresp        = bresp_q;
    assign arready      = (rstate_q == R_IDLE);
    assign rvalid       = (rstate_q == R_RESP);
    assign rdata        = rdata_q;
    assign rresp        = rresp_q;
    assign reg_wr_pulse = wr_pulse_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // A channel that has not been captured yet is taken straight from the bus,
    // so AW and W arriving together commit on the very edge they handshake.
    assign wr_addr   = aw_held_q ? awaddr_q : awaddr;
    assign wr_data   = w_held_q  ? wdata_q  : wdata;
    assign wr_strb   = w_held_q  ? wstrb_q  : wstrb;
    assign wr_commit = (wstate_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_off = wr_addr - BASE_ADDR;
    assign wr_hit = (wr_addr >= BASE_ADDR) && (wr_off[ADDR_W-1:LSB+IDX_W] == '0);
    assign wr_idx = wr_off[LSB +: IDX_W];

    assign rd_off = araddr - BASE_ADDR;
    assign rd_hit = (araddr >= BASE_ADDR) && (rd_off[ADDR_W-1:LSB+IDX_W] == '0);
    assign rd_idx = rd_off[LSB +: IDX_W];

`ifdef AXIL_REG_WSTRB_EN
    assign unused_bits = ^{wr_off[LSB-1:0], rd_off[LSB-1:0]};
`else
    assign unused_bits = ^{wr_off[LSB-1:0], rd_off[LSB-1:0], wr_strb};
`endif

    always_comb begin
        wr_word = regs_q[wr_idx];
`ifdef AXIL_REG_WSTRB_EN
        for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
                wr_word[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
`else
        wr_word = wr_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q   <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_pulse_q <= '0;
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        awaddr_q  <= awaddr;
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= wdata;
                        wstrb_q  <= wstrb;
                    end
                    if (wr_commit) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        wstate_q  <= W_RESP;
                        if (wr_hit) begin
                            regs_q[wr_idx]     <= wr_word;
                            wr_pulse_q[wr_idx] <= 1'b1;
                            bresp_q            <= RESP_OKAY;
                        end else begin
                            bresp_q <= RESP_SLVERR;
                        end
                    end
                end
                default: begin
                    if (bready) begin
                        wstate_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // regs_q is read here before the write block's non-blocking update lands,
    // so a same-edge read of the written register returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate_q <= R_RESP;
                        if (rd_hit) begin
                            rdata_q <= regs_q[rd_idx];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                    end
                end
                default: begin
                    if (rready) begin
                        rstate_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule
